// File: rtl/approx_dot_acc.sv
// -----------------------------------------------------------------------------
// approx_dot_acc
//
// Streaming accumulator that sits after the 8x8 approximate multiplier. It sums
// LEN consecutive unsigned 16-bit products into one ACC_W-bit dot-product
// result. The result is handed downstream over a valid/ready port. Overflow
// either saturates or wraps, and it is always reported with a sticky flag.
//
// Handshake semantics (both ports): a transfer happens on a rising edge where
// valid and ready are both 1. prod_ready and acc_valid are pure decodes of the
// state register, so neither depends combinationally on any input.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   clr          synchronous clear. It beats every other input.
//   prod_in      unsigned product from the multiplier
//   prod_valid   prod_in is valid
//   prod_ready   block can take a product (state ACC)
//   acc_out      accumulator register, meaningful while acc_valid=1
//   acc_valid    a completed result is held (state DONE)
//   acc_ready    downstream takes the result
//   acc_ovf      sticky: an overflow happened during the current result
//   cnt          products accepted toward the current result
//   dbg_state_o  current FSM state (0 = ACC, 1 = DONE) for observation
// -----------------------------------------------------------------------------
module approx_dot_acc #(
    parameter int unsigned LEN   = 8,   // products per result, 1..255
    parameter int unsigned ACC_W = 20,  // accumulator width, >= 16
    parameter int unsigned SAT   = 1    // 1 = saturate, 0 = wrap
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [15:0]      prod_in,
    input  logic             prod_valid,
    output logic             prod_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic             acc_ovf,
    output logic [7:0]       cnt,
    output logic             dbg_state_o
);

    typedef enum logic {
        S_ACC  = 1'b0,
        S_DONE = 1'b1
    } state_t;

    // cnt value held just before the final product of a result is accepted
    localparam logic [7:0] LAST_CNT = 8'(LEN - 1);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q,   acc_d;
    logic [7:0]         cnt_q,   cnt_d;
    logic               ovf_q,   ovf_d;
    logic [ACC_W:0]     sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        // One extra bit catches the carry-out of the addition.
        sum     = {1'b0, acc_q} + {{(ACC_W - 15){1'b0}}, prod_in};

        if (clr) begin
            state_d = S_ACC;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                S_ACC: begin
                    // prod_ready is 1 in this state, so prod_valid alone means accept.
                    if (prod_valid) begin
                        if (sum[ACC_W]) begin
                            ovf_d = 1'b1;
                            // A saturated accumulator is all-ones, so any later
                            // non-zero product carries again and stays clamped.
                            acc_d = (SAT != 0) ? '1 : sum[ACC_W-1:0];
                        end else begin
                            acc_d = sum[ACC_W-1:0];
                        end
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_q == LAST_CNT) begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // The result handoff cycle takes no product.
                    if (acc_ready) begin
                        state_d = S_ACC;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = S_ACC;
                end
            endcase
        end
    end

    assign prod_ready  = (state_q == S_ACC);
    assign acc_valid   = (state_q == S_DONE);
    assign acc_out     = acc_q;
    assign acc_ovf     = ovf_q;
    assign cnt         = cnt_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_approx_dot_acc.sv
// -----------------------------------------------------------------------------
// tb_approx_dot_acc
//
// Five accumulator instances, each with its own parameter set:
//   u0: LEN=8, ACC_W=20, SAT=1   (reset, stream, clear)
//   u1: LEN=4, ACC_W=20, SAT=1   (back-pressure and bubbles)
//   u2: LEN=2, ACC_W=16, SAT=1   (saturation)
//   u3: LEN=2, ACC_W=16, SAT=0   (wrap)
//   u4: LEN=1, ACC_W=20, SAT=1   (single-product results)
// Each instance has a model that keeps the exact running sum of the accepted
// products. The expected outputs come from that sum. A single compare
// process checks every instance on each falling edge. Directed scenarios add
// hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_approx_dot_acc;

    localparam int N = 5;
    localparam int LEN_T [N] = '{8, 4, 2, 2, 1};
    localparam int W_T   [N] = '{20, 20, 16, 16, 20};
    localparam int SAT_T [N] = '{1, 1, 1, 0, 1};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        clr        [N];
    logic [15:0] prod_in    [N];
    logic        prod_valid [N];
    logic        acc_ready  [N];
    logic        prod_ready [N];
    logic        acc_valid  [N];
    logic        acc_ovf    [N];
    logic [7:0]  cnt        [N];
    logic        dbg_state  [N];
    logic [19:0] acc_out    [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int W = W_T[g];
        logic [W-1:0] ao;
        approx_dot_acc #(
            .LEN  (LEN_T[g]),
            .ACC_W(W),
            .SAT  (SAT_T[g])
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .clr        (clr[g]),
            .prod_in    (prod_in[g]),
            .prod_valid (prod_valid[g]),
            .prod_ready (prod_ready[g]),
            .acc_out    (ao),
            .acc_valid  (acc_valid[g]),
            .acc_ready  (acc_ready[g]),
            .acc_ovf    (acc_ovf[g]),
            .cnt        (cnt[g]),
            .dbg_state_o(dbg_state[g])
        );
        assign acc_out[g] = 20'(ao);
    end

    // ---------------- scoreboard counters ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The model holds the exact mathematical sum of the accepted products, the
    // number accepted, and whether a completed result is waiting.
    longint m_total [N];
    int     m_count [N];
    bit     m_done  [N];

    initial begin
        for (int i = 0; i < N; i++) begin
            m_total[i] = 0;
            m_count[i] = 0;
            m_done[i]  = 1'b0;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < N; i++) begin
            if (!rst_n || clr[i] || (m_done[i] && acc_ready[i])) begin
                m_total[i] = 0;
                m_count[i] = 0;
                m_done[i]  = 1'b0;
            end else if (!m_done[i] && prod_valid[i]) begin
                m_total[i] = m_total[i] + longint'(prod_in[i]);
                m_count[i] = m_count[i] + 1;
                if (m_count[i] == LEN_T[i]) m_done[i] = 1'b1;
            end
        end
    end

    // Saturation clamps the true sum. Wrap takes it modulo 2^W. An overflow
    // happened exactly when the true sum no longer fits in W bits.
    function automatic logic [31:0] exp_acc(input int i);
        longint mx;
        longint r;
        mx = (longint'(1) << W_T[i]) - 1;
        if (m_total[i] > mx) r = (SAT_T[i] != 0) ? mx : (m_total[i] & mx);
        else                 r = m_total[i];
        return r[31:0];
    endfunction

    function automatic logic [31:0] exp_ovf(input int i);
        longint mx;
        mx = (longint'(1) << W_T[i]) - 1;
        return (m_total[i] > mx) ? 32'd1 : 32'd0;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            check($sformatf("u%0d.acc_out", i),    32'(acc_out[i]),    exp_acc(i));
            check($sformatf("u%0d.acc_ovf", i),    32'(acc_ovf[i]),    exp_ovf(i));
            check($sformatf("u%0d.cnt", i),        32'(cnt[i]),        32'(m_count[i]));
            check($sformatf("u%0d.acc_valid", i),  32'(acc_valid[i]),  32'(m_done[i]));
            check($sformatf("u%0d.prod_ready", i), 32'(prod_ready[i]), 32'(!m_done[i]));
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic push(input int g, input logic [15:0] p);
        prod_in[g]    = p;
        prod_valid[g] = 1'b1;
        tick();
        prod_valid[g] = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        for (int i = 0; i < N; i++) begin
            clr[i]        = 1'b0;
            prod_in[i]    = 16'h0;
            prod_valid[i] = 1'b0;
            acc_ready[i]  = 1'b0;
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        check("reset.acc_out",    32'(acc_out[0]),    32'd0);
        check("reset.acc_valid",  32'(acc_valid[0]),  32'd0);
        check("reset.prod_ready", 32'(prod_ready[0]), 32'd1);

        // Reset mid-accumulation: 5+6+7 = 18, cnt = 3, then asynchronous clear.
        push(0, 16'd5); push(0, 16'd6); push(0, 16'd7);
        check("midrst.cnt_before", 32'(cnt[0]),     32'd3);
        check("midrst.acc_before", 32'(acc_out[0]), 32'd18);
        #2 rst_n = 1'b0;
        #1;
        check("midrst.acc_out",   32'(acc_out[0]),   32'd0);
        check("midrst.cnt",       32'(cnt[0]),       32'd0);
        check("midrst.acc_ovf",   32'(acc_ovf[0]),   32'd0);
        check("midrst.acc_valid", 32'(acc_valid[0]), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("midrst.prod_ready", 32'(prod_ready[0]), 32'd1);

        // Stream 1..8 with acc_ready=1: result 36, valid for one cycle.
        acc_ready[0] = 1'b1;
        for (int k = 1; k <= 8; k++) push(0, 16'(k));
        check("stream.acc_valid", 32'(acc_valid[0]), 32'd1);
        check("stream.acc_out",   32'(acc_out[0]),   32'd36);
        check("stream.acc_ovf",   32'(acc_ovf[0]),   32'd0);
        check("stream.cnt",       32'(cnt[0]),       32'd8);
        tick();
        check("stream.valid_drop", 32'(acc_valid[0]),  32'd0);
        check("stream.ready_back", 32'(prod_ready[0]), 32'd1);

        // Back-pressure with random bubbles on u1 (LEN=4).
        acc_ready[1] = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idle($urandom_range(0, 3));
            push(1, 16'(k * 1000));
        end
        check("bp.acc_out",   32'(acc_out[1]),   32'd10000);
        check("bp.acc_valid", 32'(acc_valid[1]), 32'd1);
        prod_in[1] = 16'd55;
        prod_valid[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp.hold_acc",   32'(acc_out[1]),    32'd10000);
            check("bp.hold_ready", 32'(prod_ready[1]), 32'd0);
        end
        acc_ready[1] = 1'b1;
        tick();
        acc_ready[1] = 1'b0;
        prod_valid[1] = 1'b0;
        check("bp.release_acc", 32'(acc_out[1]), 32'd0);
        check("bp.release_cnt", 32'(cnt[1]),     32'd0);
        for (int k = 0; k < 4; k++) push(1, 16'd1);
        check("bp.next_acc", 32'(acc_out[1]), 32'd4);
        acc_ready[1] = 1'b1;
        tick();
        acc_ready[1] = 1'b0;

        // Saturation (u2) and wrap (u3): 0xFFFF + 0x0002.
        for (int k = 0; k < 2; k++) begin
            prod_in[2] = (k == 0) ? 16'hFFFF : 16'h0002;
            prod_in[3] = prod_in[2];
            prod_valid[2] = 1'b1;
            prod_valid[3] = 1'b1;
            tick();
        end
        prod_valid[2] = 1'b0;
        prod_valid[3] = 1'b0;
        check("sat.acc_out",  32'(acc_out[2]), 32'h0000FFFF);
        check("sat.acc_ovf",  32'(acc_ovf[2]), 32'd1);
        check("wrap.acc_out", 32'(acc_out[3]), 32'h00000001);
        check("wrap.acc_ovf", 32'(acc_ovf[3]), 32'd1);
        acc_ready[2] = 1'b1;
        acc_ready[3] = 1'b1;
        tick();
        check("sat.ovf_cleared", 32'(acc_ovf[2]), 32'd0);
        acc_ready[2] = 1'b0;
        acc_ready[3] = 1'b0;

        // Clear on u0: three products of 500, then clr together with a product.
        for (int k = 0; k < 3; k++) push(0, 16'd500);
        check("clr.cnt_before", 32'(cnt[0]), 32'd3);
        clr[0] = 1'b1;
        prod_in[0] = 16'd500;
        prod_valid[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        prod_valid[0] = 1'b0;
        check("clr.cnt",     32'(cnt[0]),     32'd0);
        check("clr.acc_out", 32'(acc_out[0]), 32'd0);
        for (int k = 0; k < 8; k++) push(0, 16'd100);
        check("clr.result", 32'(acc_out[0]), 32'd800);
        tick();

        // LEN=1 on u4: 7 then 9 with valid held, results two cycles apart.
        acc_ready[4] = 1'b1;
        prod_valid[4] = 1'b1;
        prod_in[4] = 16'd7;
        tick();
        check("len1.first_valid", 32'(acc_valid[4]), 32'd1);
        check("len1.first_acc",   32'(acc_out[4]),   32'd7);
        prod_in[4] = 16'd9;
        tick();
        check("len1.gap_valid", 32'(acc_valid[4]), 32'd0);
        tick();
        prod_valid[4] = 1'b0;
        check("len1.second_valid", 32'(acc_valid[4]), 32'd1);
        check("len1.second_acc",   32'(acc_out[4]),   32'd9);
        tick();
        check("len1.idle_valid", 32'(acc_valid[4]), 32'd0);

        idle(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
